// File: rtl/sort_diverter_ctrl.sv
// rtl/sort_diverter_ctrl.sv - settle/commit sequencer, belt-delay queue and diverter gate pulser
//
// Purpose: watches the scale weight and the sorter group, commits each object once
// its group reading has been stable for SETTLE cycles, delays the commit by the belt
// travel time through a small FIFO, then fires a one-hot diverter gate for PULSE cycles.
//
// Ports:
//   clk            in   1   system clock, rising edge
//   reset          in   1   synchronous, active-high
//   weight         in  12   scale reading, 0 = scale empty
//   currentGrp     in   3   sorter classification, 0 = none, 1..6 = group
//   gate           out  6   one-hot diverter drive, gate[g-1] for group g
//   commit         out  1   one-cycle pulse per committed object
//   committed_grp  out  3   group of the most recent commit
//   queue_level    out  3   number of valid belt-queue entries
//   overflow       out  1   sticky, set when a commit is dropped on a full queue
//   drop_cnt       out  8   dropped commits, saturating
//   glitch_cnt     out  8   objects removed before commit, saturating

module sort_diverter_ctrl #(
  parameter int SETTLE = 3,
  parameter int TRAVEL = 8,
  parameter int PULSE  = 2,
  parameter int DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] weight,
  input  logic [2:0]  currentGrp,
  output logic [5:0]  gate,
  output logic        commit,
  output logic [2:0]  committed_grp,
  output logic [2:0]  queue_level,
  output logic        overflow,
  output logic [7:0]  drop_cnt,
  output logic [7:0]  glitch_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_HOLD
  } state_e;

  localparam logic [3:0] SETTLE_C  = 4'(SETTLE);
  localparam logic [5:0] TRAVEL_M1 = 6'(TRAVEL - 1);
  localparam logic [3:0] PULSE_C   = 4'(PULSE);
  localparam logic [2:0] DEPTH_C   = 3'(DEPTH);

  // Settle FSM
  state_e     state_q, state_d;
  logic [2:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;

  // Registered outputs
  logic       commit_q, commit_d;
  logic [2:0] cgrp_q, cgrp_d;
  logic       overflow_q, overflow_d;
  logic [7:0] drop_q, drop_d;
  logic [7:0] glitch_q, glitch_d;

  // Belt queue: slot 0 is always the head, entries shift down on pop
  logic [2:0] grp_q [DEPTH];
  logic [2:0] grp_d [DEPTH];
  logic [5:0] tmr_q [DEPTH];
  logic [5:0] tmr_d [DEPTH];
  logic [2:0] level_q, level_d;
  logic [2:0] wr_idx;

  // Pulse generator: pcnt_q counts remaining high cycles, 0 = idle
  logic [3:0] pcnt_q, pcnt_d;
  logic [5:0] gate_q, gate_d;

  logic weight_nz, grp_nz;
  logic push_req, push_ok, pop, glitch_inc, drop_evt;

  assign weight_nz = (weight != 12'd0);
  assign grp_nz    = (currentGrp != 3'd0);

  function automatic logic [5:0] age(input logic [5:0] t);
    return (t == 6'd0) ? 6'd0 : t - 6'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Settle FSM: next state and commit decision
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    push_req   = 1'b0;
    glitch_inc = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (weight_nz) begin
          state_d = S_SETTLE;
          cand_d  = currentGrp;
          cnt_d   = {3'd0, grp_nz};
        end
      end
      S_SETTLE: begin
        if (!weight_nz) begin
          state_d    = S_IDLE;
          cnt_d      = 4'd0;
          glitch_inc = 1'b1;
        end else if (currentGrp != cand_q) begin
          cand_d = currentGrp;
          cnt_d  = {3'd0, grp_nz};
        end else if (grp_nz) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_HOLD: begin
        if (!weight_nz) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Commit in the same cycle the run length reaches SETTLE; this also covers
    // SETTLE == 1, where the very first nonzero sample from IDLE commits.
    if (state_d == S_SETTLE && grp_nz && cnt_d == SETTLE_C) begin
      push_req = 1'b1;
      state_d  = S_HOLD;
    end
  end

  // ---------------------------------------------------------------------------
  // Belt queue, pulse generator and accounting
  // ---------------------------------------------------------------------------
  always_comb begin
    // Head may leave only once its travel time is used up and no gate is active
    pop      = (level_q != 3'd0) && (tmr_q[0] == 6'd0) && (pcnt_q == 4'd0);
    // A full queue still accepts a push when the head leaves in the same cycle
    push_ok  = push_req && ((level_q != DEPTH_C) || pop);
    drop_evt = push_req && !push_ok;
    wr_idx   = pop ? (level_q - 3'd1) : level_q;

    for (int i = 0; i < DEPTH; i++) begin
      grp_d[i] = grp_q[i];
      tmr_d[i] = tmr_q[i];
    end

    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i + 1 < int'(level_q)) begin
          grp_d[i] = grp_q[i + 1];
          tmr_d[i] = age(tmr_q[i + 1]);
        end
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i < int'(level_q)) begin
          tmr_d[i] = age(tmr_q[i]);
        end
      end
    end

    // New entry lands behind the (possibly shifted) tail and is not aged this cycle
    for (int i = 0; i < DEPTH; i++) begin
      if (push_ok && i == int'(wr_idx)) begin
        grp_d[i] = cand_d;
        tmr_d[i] = TRAVEL_M1;
      end
    end

    level_d = level_q + {2'd0, push_ok} - {2'd0, pop};

    pcnt_d = pcnt_q;
    gate_d = gate_q;
    if (pop) begin
      pcnt_d = PULSE_C;
      gate_d = 6'd1 << (grp_q[0] - 3'd1);
    end else if (pcnt_q != 4'd0) begin
      pcnt_d = pcnt_q - 4'd1;
      if (pcnt_q == 4'd1) begin
        gate_d = 6'd0;
      end
    end

    commit_d   = push_req;
    cgrp_d     = push_req ? cand_d : cgrp_q;
    overflow_d = overflow_q | drop_evt;
    drop_d     = (drop_evt && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    glitch_d   = (glitch_inc && glitch_q != 8'hFF) ? glitch_q + 8'd1 : glitch_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cand_q     <= 3'd0;
      cnt_q      <= 4'd0;
      commit_q   <= 1'b0;
      cgrp_q     <= 3'd0;
      overflow_q <= 1'b0;
      drop_q     <= 8'd0;
      glitch_q   <= 8'd0;
      level_q    <= 3'd0;
      pcnt_q     <= 4'd0;
      gate_q     <= 6'd0;
      for (int i = 0; i < DEPTH; i++) begin
        grp_q[i] <= 3'd0;
        tmr_q[i] <= 6'd0;
      end
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      commit_q   <= commit_d;
      cgrp_q     <= cgrp_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      glitch_q   <= glitch_d;
      level_q    <= level_d;
      pcnt_q     <= pcnt_d;
      gate_q     <= gate_d;
      for (int i = 0; i < DEPTH; i++) begin
        grp_q[i] <= grp_d[i];
        tmr_q[i] <= tmr_d[i];
      end
    end
  end

  assign gate          = gate_q;
  assign commit        = commit_q;
  assign committed_grp = cgrp_q;
  assign queue_level   = level_q;
  assign overflow      = overflow_q;
  assign drop_cnt      = drop_q;
  assign glitch_cnt    = glitch_q;

endmodule
